// File: rtl/vga_scan_controller.sv
// vga_scan_controller: pixel-clock divider, h/v scan counters, sync/blank generation and line-prefetch scheduler
// Ports:
//   clk, rst_n                          system clock, asynchronous active-low reset
//   enable_i                            run scan; low holds the block in its idle state (synchronous)
//   pix_tick_o                          one-clk strobe every CLK_DIV clocks while enabled
//   hcount_o, vcount_o                  current pixel column and line
//   hsync_o, vsync_o                    registered syncs, active level H_POL / V_POL
//   video_on_o                          counters inside the visible area
//   frame_start_o                       one-clk pulse after the counters reach (0,0)
//   line_req_o, line_num_o, line_ack_i  line prefetch request toward the frame-buffer reader
//   underrun_o, clr_underrun_i          sticky late-fetch flag and its clear
module vga_scan_controller #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_PULSE   = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_PULSE   = 2,
  parameter int   V_BACK    = 33,
  parameter logic H_POL     = 1'b0,
  parameter logic V_POL     = 1'b0,
  parameter int   CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  output logic       pix_tick_o,
  output logic [9:0] hcount_o,
  output logic [9:0] vcount_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       video_on_o,
  output logic       frame_start_o,
  output logic       line_req_o,
  output logic [9:0] line_num_o,
  input  logic       line_ack_i,
  output logic       underrun_o,
  input  logic       clr_underrun_i
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_PULSE + V_BACK;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] H_SS   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SE   = 10'(H_VISIBLE + H_FRONT + H_PULSE);
  localparam logic [9:0] V_SS   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SE   = 10'(V_VISIBLE + V_FRONT + V_PULSE);

  typedef enum logic {IDLE, REQ} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [9:0]    hcount_q, hcount_d, vcount_q, vcount_d, line_num_q, line_num_d, next_line;
  logic          tick_q, tick_d, hsync_q, hsync_d, vsync_q, vsync_d, video_q, video_d;
  logic          frame_q, frame_d, underrun_q, underrun_d, run_q, set_ur, hwrap;

  always_comb begin
    div_d      = (!enable_i || div_q == DIV_MAX) ? '0 : div_q + DW'(1);
    tick_d     = enable_i && div_d == DIV_MAX;
    hwrap      = hcount_q == H_LAST;
    hcount_d   = !enable_i ? H_LAST : tick_q ? (hwrap ? '0 : hcount_q + 10'd1) : hcount_q;
    vcount_d   = !enable_i ? V_LAST : (tick_q && hwrap) ? (vcount_q == V_LAST ? '0 : vcount_q + 10'd1) : vcount_q;
    // sync and blanking come from the next counts so they line up with the registered counters
    hsync_d    = (enable_i && hcount_d >= H_SS && hcount_d < H_SE) ? H_POL : ~H_POL;
    vsync_d    = (enable_i && vcount_d >= V_SS && vcount_d < V_SE) ? V_POL : ~V_POL;
    video_d    = enable_i && hcount_d < H_VIS && vcount_d < V_VIS;
    frame_d    = enable_i && tick_q && hcount_d == '0 && vcount_d == '0;
    next_line  = vcount_q == V_LAST ? '0 : vcount_q + 10'd1;
    state_d    = state_q;
    line_num_d = line_num_q;
    set_ur     = 1'b0;
    if (!enable_i) begin
      state_d    = IDLE;
      line_num_d = '0;
    end else if (state_q == IDLE) begin
      // first enabled clock prefetches line 0 ahead of the first visible line
      if (!run_q) begin
        state_d    = REQ;
        line_num_d = '0;
      end else if (tick_q && hcount_d == H_VIS && next_line < V_VIS) begin
        state_d    = REQ;
        line_num_d = next_line;
      end
    end else if (line_ack_i) begin
      state_d = IDLE;
    end else if (tick_q && hcount_d == '0 && vcount_d == line_num_q) begin
      state_d = IDLE;
      set_ur  = 1'b1;
    end
    underrun_d = set_ur | (underrun_q & ~clr_underrun_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      tick_q     <= 1'b0;
      hcount_q   <= H_LAST;
      vcount_q   <= V_LAST;
      hsync_q    <= ~H_POL;
      vsync_q    <= ~V_POL;
      video_q    <= 1'b0;
      frame_q    <= 1'b0;
      state_q    <= IDLE;
      line_num_q <= '0;
      underrun_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      tick_q     <= tick_d;
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_q    <= video_d;
      frame_q    <= frame_d;
      state_q    <= state_d;
      line_num_q <= line_num_d;
      underrun_q <= underrun_d;
      run_q      <= enable_i;
    end
  end

  assign pix_tick_o    = tick_q;
  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign video_on_o    = video_q;
  assign frame_start_o = frame_q;
  assign line_req_o    = state_q == REQ;
  assign line_num_o    = line_num_q;
  assign underrun_o    = underrun_q;
endmodule
